// File: rtl/a2d_arbiter.sv
// a2d_arbiter: round-robin owner of the shared A2D SPI interface.
// Grants one of three requesters, fires strt_cnv, waits for cnv_cmplt
// (bounded by TIMEOUT cycles) and returns the result with done or err.
module a2d_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [3*NREQ-1:0]      req_chnl,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [NREQ-1:0]        err,
  output logic [11:0]            rd_data,
  output logic                   busy,
  output logic                   strt_cnv,
  output logic [2:0]             chnnl,
  input  logic                   cnv_cmplt,
  input  logic [11:0]            res
);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  // Last timer value before a WAIT is declared hung.
  localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  owner_q, owner_d;
  logic [15:0] timer_q, timer_d;
  logic [1:0]  win;

  logic [NREQ-1:0] gnt_d, done_d, err_d;
  logic [11:0]     rd_d;
  logic            busy_d, strt_d;
  logic [2:0]      chnnl_d;

  // First requester at or after last+1 (mod 3); the just-served one ends up last.
  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    pick  = 2'd0;
    found = 1'b0;
    idx   = last;
    for (int i = 0; i < 3; i++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (r[idx] && !found) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  // All outputs and control state are registered; async reset abandons any conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 2'd2;
      owner_q  <= 2'd0;
      timer_q  <= 16'd0;
      gnt      <= '0;
      done     <= '0;
      err      <= '0;
      rd_data  <= 12'd0;
      busy     <= 1'b0;
      strt_cnv <= 1'b0;
      chnnl    <= 3'd0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      timer_q  <= timer_d;
      gnt      <= gnt_d;
      done     <= done_d;
      err      <= err_d;
      rd_data  <= rd_d;
      busy     <= busy_d;
      strt_cnv <= strt_d;
      chnnl    <= chnnl_d;
    end
  end

  // Next-state and next-output logic; done/err/strt_cnv default low so they pulse.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    timer_d = timer_q;
    gnt_d   = gnt;
    done_d  = '0;
    err_d   = '0;
    rd_d    = rd_data;
    busy_d  = busy;
    strt_d  = 1'b0;
    chnnl_d = chnnl;
    win     = pick(req, last_q);
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          owner_d = win;
          gnt_d   = 3'(3'b001 << win);
          busy_d  = 1'b1;
          strt_d  = 1'b1;
          case (win)
            2'd0:    chnnl_d = req_chnl[2:0];
            2'd1:    chnnl_d = req_chnl[5:3];
            default: chnnl_d = req_chnl[8:6];
          endcase
          state_d = START;
        end
      end
      START: begin
        timer_d = 16'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnv_cmplt) begin
          rd_d    = res;
          done_d  = gnt;
          gnt_d   = '0;
          busy_d  = 1'b0;
          last_d  = owner_q;
          state_d = IDLE;
        end else if (timer_q == TMAX) begin
          err_d   = gnt;
          gnt_d   = '0;
          busy_d  = 1'b0;
          last_d  = owner_q;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/a2d_arbiter.md
Name: a2d_arbiter

Overview:
- Shares the single A2D SPI interface (A2D_intf) between up to three requesters: the slide-pot scanner, the battery monitor and a spare/debug port.
- Grants the converter round-robin, drives chnnl/strt_cnv, waits for cnv_cmplt, and returns the 12-bit result with a done pulse to the owner.
- Aborts a hung conversion after a timeout and signals an error to the owner.

Parameters:
- NREQ, 3, number of requesters; fixed at 3 for this design.
- TIMEOUT, 4096, max cycles in WAIT before abort; range 2 to 65535.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req  input  3  level request per requester; held until that requester's done or err
- req_chnl  input  9  {chnl2,chnl1,chnl0}; 3-bit A2D channel per requester
- gnt  output  3  one-hot current owner; 0 when idle
- done  output  3  one-cycle pulse to owner when the result is valid
- err  output  3  one-cycle pulse to owner on timeout abort
- rd_data  output  12  last completed conversion result
- busy  output  1  high from grant through done/err
- strt_cnv  output  1  start pulse to A2D_intf
- chnnl  output  3  channel to A2D_intf
- cnv_cmplt  input  1  conversion-complete from A2D_intf
- res  input  12  result from A2D_intf

Behaviour:
- All outputs are registered.
- Reset values: gnt=0, done=0, err=0, rd_data=0, busy=0, strt_cnv=0, chnnl=0, last-owner pointer=2 (so requester 0 has first priority), timer=0, state=IDLE. Reset is asynchronous and effective mid-operation: everything returns to reset values immediately and any in-flight conversion is abandoned with no done/err.
- States: IDLE, START, WAIT.
- IDLE:
  - req is sampled only in this state.
  - If req!=0, the winner is the first set bit searching from (last_owner+1) mod 3 upward with wrap.
  - On that edge: gnt=onehot(winner), busy=1, chnnl=req_chnl slice of the winner (latched), strt_cnv=1; go to START.
- START:
  - strt_cnv is high for exactly this one cycle.
  - Next edge: strt_cnv=0, timer=0; go to WAIT.
  - cnv_cmplt is ignored in START.
- WAIT:
  - The timer increments each cycle.
  - If cnv_cmplt=1: rd_data=res, done[owner]=1 for one cycle, gnt=0, busy=0, last_owner=owner; go to IDLE.
  - Else if timer==TIMEOUT-1: err[owner]=1 for one cycle, rd_data unchanged, gnt=0, busy=0, last_owner=owner; go to IDLE.
  - cnv_cmplt and the timeout on the same cycle: cnv_cmplt wins (done, no err).
- cnv_cmplt seen in IDLE is ignored; no output changes.
- chnnl stays stable from grant until the next grant; it is not cleared on done.
- A requester dropping req mid-service does not abort: the conversion completes and done still pulses.
- req_chnl changes after the grant are ignored.
- Minimum latency: req high at edge k, then strt_cnv high in cycle k+1, WAIT from k+2. done pulses on the edge after cnv_cmplt is sampled high. The next grant is earliest on the edge after done. Back-to-back service therefore has a 1-cycle IDLE gap.
- Fairness: with all three requesting continuously, grants rotate 0,1,2,0,... The requester just served becomes lowest priority.
- done and err are never both high, and never high for a non-owner.

Test Plan:
- Single request: req=001, req_chnl[2:0]=3'd4. Expect strt_cnv 1 cycle later for exactly 1 cycle, chnnl=4. Drive cnv_cmplt with res=12'hA5C after 30 cycles. Expect done=001 next cycle, rd_data=12'hA5C, busy=0.
- Simultaneous requests: req=111 held, channels 0/1/7. Expect grants in order 001, 010, 100, each done pulse correct, chnnl 0, 1, 7 respectively, and a 1-cycle IDLE gap between services.
- Fairness after service: requester 0 served, then req=011 held. Expect the next grant to be 010, not 001.
- Timeout: TIMEOUT=16, req=010, cnv_cmplt never asserted. Expect err=010 exactly 16 cycles after entering WAIT, rd_data unchanged, done stays 0, next request is accepted.
- Race: assert cnv_cmplt on the final timeout cycle with res=12'h123. Expect done pulses, err=0, rd_data=12'h123.
- Reset mid-WAIT: assert rst_n=0 during WAIT. Expect all outputs 0 immediately. Then, with req=100 after reset release, expect a grant to requester 2, because the pointer restarts and 0 would be preferred only if it were also requesting.
